xgmii_rx_align: RTL

XGMII_RX_ALIGN -- requirements
Module: xgmii_rx_align

---
 rtl/xgmii_rx_align_if.sv | 28 ++
 rtl/xgmii_rx_align.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/xgmii_rx_align_if.sv
// xgmii_rx_align_if: raw XGMII receive bus in, lane-7 aligned bus out.
// Signals: i_xgmii_rxd/rxc raw in; o_xgmii_rxd/rxc, o_lane4_sof, o_overlen_err out.
interface xgmii_rx_align_if;
  logic [63:0] i_xgmii_rxd;
  logic [7:0]  i_xgmii_rxc;
  logic [63:0] o_xgmii_rxd;
  logic [7:0]  o_xgmii_rxc;
  logic        o_lane4_sof;
  logic        o_overlen_err;

  modport master (
    output i_xgmii_rxd,
    output i_xgmii_rxc,
    input  o_xgmii_rxd,
    input  o_xgmii_rxc,
    input  o_lane4_sof,
    input  o_overlen_err
  );

  modport slave (
    input  i_xgmii_rxd,
    input  i_xgmii_rxc,
    output o_xgmii_rxd,
    output o_xgmii_rxc,
    output o_lane4_sof,
    output o_overlen_err
  );
endinterface

// File: rtl/xgmii_rx_align.sv
// xgmii_rx_align: moves a lane-3 SOF to lane 7 so the MAC always sees SOF in lane 7.
// Ports: i_xgmii_clk, i_xgmii_rst_n (async low), bus (slave: raw in, aligned out + pulses).
module xgmii_rx_align #(
  parameter int P_MAX_WORDS = 200
) (
  input  logic            i_xgmii_clk,
  input  logic            i_xgmii_rst_n,
  xgmii_rx_align_if.slave bus
);

  localparam logic [63:0] IDLE_D  = {8{8'h07}};
  localparam logic [63:0] ABORT_D = {8{8'hFE}};
  localparam logic [7:0]  C_S     = 8'hFB;
  localparam logic [7:0]  C_T     = 8'hFD;
  localparam int CL = $clog2(P_MAX_WORDS + 1);
  localparam int CW = (CL > 8) ? CL : 8;
  localparam logic [CW-1:0] MAXC = CW'(P_MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SHIFT
  } state_t;

  logic [1:0]    rst_sync;
  logic          rst_n;

  state_t        state, state_nxt;
  logic [63:0]   prev_d;
  logic [7:0]    prev_c;
  logic [63:0]   out_d, d_nxt;
  logic [7:0]    out_c, c_nxt;
  logic          sof4, sof_nxt;
  logic          ovl, ovl_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          uhc, uhc_nxt;

  logic [63:0]   sh_d, word_d;
  logic [7:0]    sh_c, word_c;
  logic          sof7, sof3, has_t;

  // Assert passes straight through; release waits two edges.
  always_ff @(posedge i_xgmii_clk or negedge i_xgmii_rst_n) begin
    if (!i_xgmii_rst_n) rst_sync <= 2'b00;
    else                rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  assign sh_d = {prev_d[31:0], bus.i_xgmii_rxd[63:32]};
  assign sh_c = {prev_c[3:0], bus.i_xgmii_rxc[7:4]};

  assign sof7 = prev_c[7] && (prev_d[63:56] == C_S);
  assign sof3 = prev_c[3] && (prev_d[31:24] == C_S)
             && (prev_c[7:4] == 4'hF);

  always_comb begin
    word_d = prev_d;
    word_c = prev_c;
    if (state == SHIFT) begin
      word_d = sh_d;
      word_c = sh_c;
    end
  end

  always_comb begin
    has_t = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (word_c[k] && (word_d[8*k +: 8] == C_T)) has_t = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    d_nxt     = IDLE_D;
    c_nxt     = 8'hFF;
    sof_nxt   = 1'b0;
    ovl_nxt   = 1'b0;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        // uhc: upper half of prev_d already went out in the last shifted word
        if (sof7 && !uhc) begin
          d_nxt     = prev_d;
          c_nxt     = prev_c;
          cnt_nxt   = CW'(1);
          state_nxt = DIRECT;
        end else if (sof3) begin
          d_nxt     = sh_d;
          c_nxt     = sh_c;
          sof_nxt   = 1'b1;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
      end
      DIRECT, SHIFT: begin
        if (cnt >= MAXC) begin
          d_nxt     = ABORT_D;
          ovl_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          d_nxt   = word_d;
          c_nxt   = word_c;
          cnt_nxt = cnt + CW'(1);
          if (has_t) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    uhc_nxt = (state == SHIFT) && (state_nxt == IDLE);
  end

  always_ff @(posedge i_xgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      prev_d <= IDLE_D;
      prev_c <= 8'hFF;
      out_d  <= IDLE_D;
      out_c  <= 8'hFF;
      sof4   <= 1'b0;
      ovl    <= 1'b0;
      cnt    <= '0;
      uhc    <= 1'b0;
    end else begin
      state  <= state_nxt;
      prev_d <= bus.i_xgmii_rxd;
      prev_c <= bus.i_xgmii_rxc;
      out_d  <= d_nxt;
      out_c  <= c_nxt;
      sof4   <= sof_nxt;
      ovl    <= ovl_nxt;
      cnt    <= cnt_nxt;
      uhc    <= uhc_nxt;
    end
  end

  assign bus.o_xgmii_rxd   = out_d;
  assign bus.o_xgmii_rxc   = out_c;
  assign bus.o_lane4_sof   = sof4;
  assign bus.o_overlen_err = ovl;

endmodule
